// File: rtl/fpu_seq_pkg.sv
// Shared FPU op encodings and sequencer state type; the ALU decoder imports the
// same code constants so both sides agree on the alu_cont values.
package fpu_seq_pkg;

  localparam logic [3:0] FPU_FADD  = 4'b1000;
  localparam logic [3:0] FPU_FSUB  = 4'b1001;
  localparam logic [3:0] FPU_FMUL  = 4'b1010;
  localparam logic [3:0] FPU_FDIV  = 4'b1011;
  localparam logic [3:0] FPU_FSQRT = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic logic is_fpu_code(input logic [3:0] code);
    return (code == FPU_FADD) || (code == FPU_FSUB) || (code == FPU_FMUL) ||
           (code == FPU_FDIV) || (code == FPU_FSQRT);
  endfunction

endpackage

// File: rtl/fpu_lat_lookup.sv
// Combinational decode of an FPU code into {legal, latency-1}; the latency-1
// value is loaded straight into the sequencer's down-counter.
module fpu_lat_lookup
  import fpu_seq_pkg::*;
#(
  parameter int LAT_FADD  = 2,
  parameter int LAT_FMUL  = 2,
  parameter int LAT_FDIV  = 10,
  parameter int LAT_FSQRT = 12,
  parameter int CNT_W     = 4
) (
  input  logic [3:0]       alu_cont,
  output logic             legal,
  output logic [CNT_W-1:0] lat_m1
);

  always_comb begin
    legal  = is_fpu_code(alu_cont);
    lat_m1 = '0;
    case (alu_cont)
      FPU_FADD, FPU_FSUB: lat_m1 = CNT_W'(LAT_FADD - 1);
      FPU_FMUL:           lat_m1 = CNT_W'(LAT_FMUL - 1);
      FPU_FDIV:           lat_m1 = CNT_W'(LAT_FDIV - 1);
      FPU_FSQRT:          lat_m1 = CNT_W'(LAT_FSQRT - 1);
      default:            lat_m1 = '0;
    endcase
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issues one multi-cycle FPU op from EX, stalls the pipe while it runs and
// returns the captured result with a single-cycle valid pulse.
//
// state | meaning
// IDLE  | waiting for an FPU op from EX; stall only in the issue cycle
// RUN   | op in flight, down-counter running, pipe stalled
// DONE  | result valid for one cycle, pipe released
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int LAT_FADD  = 2,
  parameter int LAT_FMUL  = 2,
  parameter int LAT_FDIV  = 10,
  parameter int LAT_FSQRT = 12,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  alu_cont,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        flush,
  input  logic [31:0] fpu_result,
  output logic [2:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_en,
  output logic        stall,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        illegal_op
);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             legal;
  logic [CNT_W-1:0] lat_m1;
  logic             issue;
  logic             reject;
  logic             capture;

  fpu_lat_lookup #(
    .LAT_FADD (LAT_FADD),
    .LAT_FMUL (LAT_FMUL),
    .LAT_FDIV (LAT_FDIV),
    .LAT_FSQRT(LAT_FSQRT),
    .CNT_W    (CNT_W)
  ) u_lat (
    .alu_cont(alu_cont),
    .legal   (legal),
    .lat_m1  (lat_m1)
  );

  // start while DONE belongs to the instruction just retired, so only IDLE issues
  assign issue   = (state == ST_IDLE) && start && legal && !flush;
  assign reject  = (state == ST_IDLE) && start && !legal && !flush;
  assign capture = (state == ST_RUN) && !flush && (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (issue) begin
          state_nxt = ST_RUN;
          cnt_nxt   = lat_m1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      fpu_op     <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      result     <= '0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      illegal_op <= reject;
      if (issue) begin
        fpu_op <= alu_cont[2:0];
        fpu_a  <= rs1_val;
        fpu_b  <= rs2_val;
      end
      if (capture) begin
        result <= fpu_result;
      end
    end
  end

  assign fpu_en       = (state == ST_RUN);
  assign result_valid = (state == ST_DONE);
  assign stall        = issue || (state == ST_RUN);

endmodule
